// File: rtl/register_file_pkg.sv
// Shared sizing constants and index/word types for the register file.
package register_file_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [DATA_WIDTH-1:0] word_t;
endpackage

// File: rtl/register_file_if.sv
// Read/write bus of the register file: four read indices, one write port,
// four registered read outputs.
interface register_file_if
  import register_file_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = ADDR_WIDTH
);
  logic [AW-1:0] srcA, srcB, srcC, srcD;
  logic          writeEnable;
  logic [AW-1:0] dest;
  logic [DW-1:0] writeData;
  logic [DW-1:0] outputA, outputB, outputC, outputD;

  modport master (
    output srcA, srcB, srcC, srcD, writeEnable, dest, writeData,
    input  outputA, outputB, outputC, outputD
  );

  modport slave (
    input  srcA, srcB, srcC, srcD, writeEnable, dest, writeData,
    output outputA, outputB, outputC, outputD
  );
endinterface

// File: rtl/register_file_read_port.sv
// One read port: captures the selected register on the falling clock edge,
// forcing index 0 to read as zero.
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [AW-1:0]              idx_i,
  input  logic [2**AW-1:0][DW-1:0]   regs_i,
  output logic [DW-1:0]              data_o
);
  logic [DW-1:0] data_q, data_d;

  // Zero-force index 0 so x0 never depends on the array contents.
  always_comb begin
    data_d = '0;
    if (idx_i != '0) data_d = regs_i[idx_i];
  end

  // Falling-edge capture; reset clears and holds the output at 0.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign data_o = data_q;
endmodule

// File: rtl/register_file.sv
// 32 x 32 register file: rising-edge write, four falling-edge registered reads.
// Writes land half a cycle before the reads sample, so same-cycle
// write-then-read returns the new value without a bypass path.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  register_file_if.slave bus
);
  localparam int NR = 2 ** ADDR_WIDTH;

  logic [NR-1:0][DATA_WIDTH-1:0] regs_q;
  logic [3:0][ADDR_WIDTH-1:0]    src;
  logic [3:0][DATA_WIDTH-1:0]    rd;

  // Storage: writes to x0 are dropped so regs_q[0] stays 0 forever.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '0;
    end else if (bus.writeEnable && (bus.dest != '0)) begin
      regs_q[bus.dest] <= bus.writeData;
    end
  end

  assign src = {bus.srcD, bus.srcC, bus.srcB, bus.srcA};

  for (genvar p = 0; p < 4; p++) begin : g_rd
    register_file_read_port #(
      .DW(DATA_WIDTH),
      .AW(ADDR_WIDTH)
    ) u_rd (
      .clk   (clk),
      .reset (reset),
      .idx_i (src[p]),
      .regs_i(regs_q),
      .data_o(rd[p])
    );
  end

  assign bus.outputA = rd[0];
  assign bus.outputB = rd[1];
  assign bus.outputC = rd[2];
  assign bus.outputD = rd[3];
endmodule

// File: tb/tb_register_file.sv
// Directed plus random checks of register_file against an array model.
module tb_register_file;
  import register_file_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  register_file_if bus ();

  register_file dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference: architectural register contents and last expected outputs.
  word_t mem [NUM_REGS];
  word_t exp_o [4];

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".A"}, bus.outputA, exp_o[0]);
    chk({tag, ".B"}, bus.outputB, exp_o[1]);
    chk({tag, ".C"}, bus.outputC, exp_o[2]);
    chk({tag, ".D"}, bus.outputD, exp_o[3]);
  endtask

  function automatic word_t rd(input reg_idx_t i);
    return (i == 0) ? word_t'(0) : mem[i];
  endfunction

  // One full cycle: drive during the low phase, write at rising edge,
  // check outputs 1 ns after the falling edge.
  task automatic cyc(input string tag, input logic we, input reg_idx_t d,
                     input word_t wd, input reg_idx_t a, input reg_idx_t b,
                     input reg_idx_t c, input reg_idx_t e);
    bus.writeEnable = we; bus.dest = d; bus.writeData = wd;
    bus.srcA = a; bus.srcB = b; bus.srcC = c; bus.srcD = e;
    #1;
    chk_outs({tag, ".hold"});
    @(posedge clk);
    if (we && d != 0) mem[d] = wd;
    @(negedge clk);
    exp_o[0] = rd(a); exp_o[1] = rd(b); exp_o[2] = rd(c); exp_o[3] = rd(e);
    #1;
    chk_outs(tag);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = '0;
    foreach (exp_o[i]) exp_o[i] = '0;
    bus.writeEnable = 1'b1; bus.dest = 5'd1; bus.writeData = 32'hA5A5A5A5;
    bus.srcA = 5'd1; bus.srcB = 5'd1; bus.srcC = 5'd1; bus.srcD = 5'd1;

    // Writes under reset are ignored and outputs stay 0.
    @(negedge clk); #2;
    chk_outs("reset");
    reset = 1'b0;

    cyc("wr_x1",   1'b1, 5'd1,  32'hDEADBEEF, 5'd0, 5'd0, 5'd0, 5'd0);
    cyc("rd_x1",   1'b0, 5'd0,  32'h0,        5'd1, 5'd0, 5'd0, 5'd0);
    cyc("wr_x0",   1'b1, 5'd0,  32'hFFFFFFFF, 5'd1, 5'd0, 5'd0, 5'd0);
    cyc("rd_x0",   1'b0, 5'd0,  32'h0,        5'd1, 5'd0, 5'd0, 5'd0);
    chk("x0_zero", bus.outputB, 32'h0);
    chk("x1_keep", bus.outputA, 32'hDEADBEEF);
    cyc("wr_x5",   1'b1, 5'd5,  32'h11111111, 5'd1, 5'd0, 5'd0, 5'd0);
    cyc("wr_x6",   1'b1, 5'd6,  32'h22222222, 5'd1, 5'd0, 5'd0, 5'd0);
    cyc("wr_x7",   1'b1, 5'd7,  32'h33333333, 5'd1, 5'd0, 5'd0, 5'd0);
    cyc("wr_x8",   1'b1, 5'd8,  32'h44444444, 5'd1, 5'd0, 5'd0, 5'd0);
    cyc("rd_5678", 1'b0, 5'd0,  32'h0,        5'd5, 5'd6, 5'd7, 5'd8);
    chk("x8_lit",  bus.outputD, 32'h44444444);
    cyc("rd_dup7", 1'b0, 5'd0,  32'h0,        5'd7, 5'd7, 5'd7, 5'd7);
    chk("dup7_lit", bus.outputB, 32'h33333333);
    cyc("wr_rd31", 1'b1, 5'd31, 32'hCAFEF00D, 5'd1, 5'd0, 5'd31, 5'd0);
    chk("x31_lit", bus.outputC, 32'hCAFEF00D);
    cyc("we_off",  1'b0, 5'd1,  32'h12345678, 5'd1, 5'd1, 5'd31, 5'd1);
    chk("x1_lit",  bus.outputA, 32'hDEADBEEF);

    // Randomized traffic, including duplicate indices and x0 writes.
    for (int n = 0; n < 60; n++) begin
      cyc("rand", 1'($urandom), reg_idx_t'($urandom), word_t'($urandom),
          reg_idx_t'($urandom), reg_idx_t'($urandom),
          reg_idx_t'($urandom), reg_idx_t'($urandom));
    end

    // Reset between a write's rising edge and the read's falling edge.
    cyc("pre_rst", 1'b0, 5'd0, 32'h0, 5'd1, 5'd31, 5'd5, 5'd8);
    bus.writeEnable = 1'b1; bus.dest = 5'd1; bus.writeData = 32'h5555AAAA;
    @(posedge clk); #2;
    reset = 1'b1;
    foreach (mem[i]) mem[i] = '0;
    foreach (exp_o[i]) exp_o[i] = '0;
    #1;
    chk_outs("rst_async");
    @(negedge clk); #1;
    chk_outs("rst_hold");
    reset = 1'b0;
    cyc("post_rst", 1'b0, 5'd0, 32'h0, 5'd1, 5'd31, 5'd1, 5'd31);
    chk("post_x1", bus.outputA, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register/data width; the SHALL statements below use the default.
REQ-002 Parameter ADDR_WIDTH, default 5, register index width; 2**ADDR_WIDTH = 32 registers.
REQ-003 clk  input  1  single clock; writes on rising edge, reads captured on falling edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 srcA, srcB, srcC, srcD  input  5 each  read-port register indices.
REQ-006 writeEnable  input  1  write strobe, sampled at rising clk.
REQ-007 dest  input  5  write register index.
REQ-008 writeData  input  32  write data.
REQ-009 outputA, outputB, outputC, outputD  output  32 each  registered read data for ports A-D.

Function
REQ-010 The block SHALL hold 32 registers x0..x31 of 32 bits.
REQ-011 On rising clk with writeEnable=1 and dest!=0, the block SHALL store writeData into register[dest].
REQ-012 Writes with dest=0 SHALL be discarded; x0 SHALL always read 0.
REQ-013 writeEnable=0 SHALL leave all registers unchanged.
REQ-014 On each falling clk, each output SHALL load the current contents of the register selected by its src index; 0 when the index is 0.
REQ-015 The four read ports SHALL be independent; any combination of indices, including duplicates, SHALL be legal.
REQ-016 Read latency: a src change made after a rising edge SHALL appear on its output at the next falling edge; the output SHALL hold until the following falling edge.
REQ-017 Write-then-read: a write committed at rising edge N SHALL be visible on any port reading that index at the falling edge in the same cycle. No extra bypass path is required.
REQ-018 Outputs SHALL NOT change combinationally with src inputs between falling edges.
REQ-019 Simultaneous write and read of the same index in a cycle SHALL return the newly written value at that cycle's falling edge, per REQ-017.
REQ-020 Out-of-range conditions cannot occur: all 5-bit indices are valid.

Reset
REQ-021 Asserting reset SHALL asynchronously clear all 32 registers and all four outputs to 32'h0.
REQ-022 While reset is high, writes SHALL be ignored and outputs SHALL remain 0.
REQ-023 After reset deasserts, normal operation SHALL resume at the next clk edge of each type.
REQ-024 Reset asserted mid-cycle, including between a write's rising edge and the read's falling edge, SHALL override that pending data; the subsequent read SHALL return 0.

Structure
REQ-025 A shared package SHALL hold DATA_WIDTH, ADDR_WIDTH, the NUM_REGS constant, and a reg-index typedef (5-bit) and word typedef (32-bit).
REQ-026 The storage array and write logic SHALL reside in register_file.
REQ-027 The falling-edge capture SHALL be one sub-module, register_file_read_port, instantiated four times. Each instance takes an index and the array and produces a zero-forced registered output.
REQ-028 The design SHALL be synthesizable for iCE40: no latches, no initial blocks required for function.

Verification
REQ-029 Write 0xDEADBEEF to x1 (writeEnable=1, dest=1, one rising edge), then srcA=1 -> outputA=0xDEADBEEF 1 ns after the next falling edge.
REQ-030 Write 0xFFFFFFFF to x0, then srcB=0 -> outputB=0x00000000 after the next falling edge; outputA still 0xDEADBEEF.
REQ-031 Write distinct values (0x11111111, 0x22222222, 0x33333333, 0x44444444) to x5..x8, then srcA..srcD=5..8 -> the four ports each return their own value on the same falling edge; then set all src=7 -> all four ports return 0x33333333.
REQ-032 Write 0xCAFEF00D to x31 with srcC=31 set at the same rising edge -> outputC=0xCAFEF00D at that cycle's falling edge.
REQ-033 writeEnable=0, dest=1, writeData=0x12345678 -> x1 still reads 0xDEADBEEF.
REQ-034 Assert reset asynchronously between clock edges -> all outputs 0 immediately; after release, reading x1 and x31 -> 0.
